candle_command_sequencer: RTL and testbench

- Command-side initiator for the candle controller. It drives `pos_to_set`/`set_enable` and `pos_to_clear`/`clear_enable`, and reads back `candle_state`.
- It accepts a full 8-bit target pattern over a valid/ready handshake. It then issues single-position set/clear commands until `candle_state` equals the target.
- On completion it pulses `done`. If the commands are not taking effect (command budget exhausted), it flags `error`.
- Sits between host/pattern logic and the candle controller, replacing hand-driven enable sequencing.

---
 rtl/candle_command_sequencer.sv | 163 ++++++++++++++++
 tb/tb_candle_command_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/candle_command_sequencer.sv
// candle_command_sequencer
// Accepts an 8-bit target candle pattern over a valid/ready handshake. It then issues
// single-position set/clear strobes to the candle controller until candle_state matches
// the target. When the patterns match it pulses done. If the command budget runs out
// first, it raises a sticky error.
//
// Optional feature: define CANDLE_SEQ_DUAL_CMD_EN to issue one set and one clear in the
// same ISSUE cycle whenever both are needed. The pair counts as a single command.
//
// Ports:
//   sys_clk        in   clock, rising edge
//   clr_async      in   asynchronous active-high reset
//   target_pattern in   [7:0] requested pattern, bit i = candle i lit
//   target_valid   in   target_pattern valid
//   target_ready   out  idle, can accept a target
//   candle_state   in   [7:0] feedback from the candle controller
//   pos_to_set     out  [2:0] position to set (holds while set_enable low)
//   set_enable     out  set strobe
//   pos_to_clear   out  [2:0] position to clear (holds while clear_enable low)
//   clear_enable   out  clear strobe
//   busy           out  not idle
//   done           out  one-cycle pulse on match
//   error          out  sticky, budget exhausted without match
module candle_command_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned MAX_CMDS      = 16
) (
  input  logic       sys_clk,
  input  logic       clr_async,
  input  logic [7:0] target_pattern,
  input  logic       target_valid,
  output logic       target_ready,
  input  logic [7:0] candle_state,
  output logic [2:0] pos_to_set,
  output logic       set_enable,
  output logic [2:0] pos_to_clear,
  output logic       clear_enable,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CntW    = $clog2(MAX_CMDS + 1);
  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle, StCompare, StIssue, StSettle, StDone, StFail
  } state_e;

  state_e             r_state;
  logic [7:0]         r_target;
  logic [CntW-1:0]    r_cnt;
  logic [SettleW-1:0] r_settle;
  logic [2:0]         r_pos_set;
  logic [2:0]         r_pos_clr;
  logic               r_set_en;
  logic               r_clr_en;
  logic               r_done;
  logic               r_error;

  logic [7:0] w_need_set;
  logic [7:0] w_need_clr;
  logic [2:0] w_set_idx;
  logic [2:0] w_clr_idx;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_need_set = r_target & ~candle_state;
    w_need_clr = ~r_target & candle_state;
    w_set_idx  = lowest_idx(w_need_set);
    w_clr_idx  = lowest_idx(w_need_clr);
  end

  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      r_state   <= StIdle;
      r_target  <= 8'h00;
      r_cnt     <= '0;
      r_settle  <= '0;
      r_pos_set <= 3'd0;
      r_pos_clr <= 3'd0;
      r_set_en  <= 1'b0;
      r_clr_en  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; only COMPARE re-arms them.
      r_set_en <= 1'b0;
      r_clr_en <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (target_valid) begin
            r_target <= target_pattern;
            r_error  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= StCompare;
          end
        end
        StCompare: begin
          if (w_need_set == 8'h00 && w_need_clr == 8'h00) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (r_cnt == CntW'(MAX_CMDS)) begin
            r_error <= 1'b1;
            r_state <= StFail;
          end else begin
`ifdef CANDLE_SEQ_DUAL_CMD_EN
            // Set and clear vectors are disjoint, so the two positions never collide.
            if (w_need_set != 8'h00) begin
              r_set_en  <= 1'b1;
              r_pos_set <= w_set_idx;
            end
            if (w_need_clr != 8'h00) begin
              r_clr_en  <= 1'b1;
              r_pos_clr <= w_clr_idx;
            end
`else
            if (w_need_set != 8'h00) begin
              r_set_en  <= 1'b1;
              r_pos_set <= w_set_idx;
            end else begin
              r_clr_en  <= 1'b1;
              r_pos_clr <= w_clr_idx;
            end
`endif
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_cnt    <= r_cnt + CntW'(1);
          r_settle <= SettleW'(SETTLE_CYCLES - 1);
          r_state  <= StSettle;
        end
        StSettle: begin
          if (r_settle == '0) r_state <= StCompare;
          else                r_settle <= r_settle - SettleW'(1);
        end
        StDone:  r_state <= StIdle;
        StFail:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign target_ready = (r_state == StIdle);
  assign busy         = (r_state != StIdle);
  assign pos_to_set   = r_pos_set;
  assign set_enable   = r_set_en;
  assign pos_to_clear = r_pos_clr;
  assign clear_enable = r_clr_en;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_candle_command_sequencer.sv
module tb_candle_command_sequencer;

  typedef struct packed {
    int         cyc;
    logic       s;
    logic [2:0] ps;
    logic       c;
    logic [2:0] pc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters. DUT B: MAX_CMDS=4, its controller ignores sets on bit 6.
  logic [7:0] tp_a = '0, tp_b = '0;
  logic       tv_a = 1'b0, tv_b = 1'b0;
  logic [7:0] st_a = '0, st_b = '0;
  logic       pre_en_a = 1'b0, pre_en_b = 1'b0;
  logic [7:0] pre_val_a = '0, pre_val_b = '0;
  logic       rdy_a, busy_a, done_a, err_a, se_a, ce_a;
  logic       rdy_b, busy_b, done_b, err_b, se_b, ce_b;
  logic [2:0] ps_a, pc_a, ps_b, pc_b;

  candle_command_sequencer u_dut_a (
    .sys_clk(clk), .clr_async(rst), .target_pattern(tp_a), .target_valid(tv_a),
    .target_ready(rdy_a), .candle_state(st_a), .pos_to_set(ps_a), .set_enable(se_a),
    .pos_to_clear(pc_a), .clear_enable(ce_a), .busy(busy_a), .done(done_a), .error(err_a)
  );

  candle_command_sequencer #(.SETTLE_CYCLES(1), .MAX_CMDS(4)) u_dut_b (
    .sys_clk(clk), .clr_async(rst), .target_pattern(tp_b), .target_valid(tv_b),
    .target_ready(rdy_b), .candle_state(st_b), .pos_to_set(ps_b), .set_enable(se_b),
    .pos_to_clear(pc_b), .clear_enable(ce_b), .busy(busy_b), .done(done_b), .error(err_b)
  );

  // Behavioural candle controllers.
  always @(posedge clk) begin
    if (pre_en_a) st_a <= pre_val_a;
    else begin
      if (se_a) st_a[ps_a] <= 1'b1;
      if (ce_a) st_a[pc_a] <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (pre_en_b) st_b <= pre_val_b;
    else begin
      if (se_b && ps_b != 3'd6) st_b[ps_b] <= 1'b1;
      if (ce_b) st_b[pc_b] <= 1'b0;
    end
  end

  ev_t ev_a[$];
  ev_t ev_b[$];
  int  dn_a[$];
  int  dn_b[$];

  always @(negedge clk) begin
    if (se_a || ce_a) ev_a.push_back('{cyc, se_a, ps_a, ce_a, pc_a});
    if (se_b || ce_b) ev_b.push_back('{cyc, se_b, ps_b, ce_b, pc_b});
    if (done_a) dn_a.push_back(cyc);
    if (done_b) dn_b.push_back(cyc);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input ev_t e, input int c_exp, input logic s,
                        input logic [2:0] ps, input logic c, input logic [2:0] pc);
    check_eq({tag, "_cyc"}, e.cyc, c_exp);
    check_eq({tag, "_set"}, {31'd0, e.s}, {31'd0, s});
    check_eq({tag, "_clr"}, {31'd0, e.c}, {31'd0, c});
    if (s) check_eq({tag, "_pset"}, {29'd0, e.ps}, {29'd0, ps});
    if (c) check_eq({tag, "_pclr"}, {29'd0, e.pc}, {29'd0, pc});
  endtask

  task automatic preset(input bit sel_b, input logic [7:0] v);
    @(negedge clk);
    if (sel_b) begin pre_val_b = v; pre_en_b = 1'b1; end
    else begin pre_val_a = v; pre_en_a = 1'b1; end
    @(negedge clk);
    pre_en_a = 1'b0;
    pre_en_b = 1'b0;
  endtask

  // Returns the cycle stamp of the accept edge as seen by the negedge monitor.
  task automatic send(input bit sel_b, input logic [7:0] p, output int acc);
    @(negedge clk);
    check_eq("ready_before_send", {31'd0, sel_b ? rdy_b : rdy_a}, 32'd1);
    if (sel_b) begin tp_b = p; tv_b = 1'b1; end
    else begin tp_a = p; tv_a = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    acc  = cyc;
    tv_a = 1'b0;
    tv_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel_b);
    int n;
    n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", {31'd0, sel_b ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    int acc, e0, d0, n;

    // 1. Reset with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tp_a = 8'($urandom);
      tv_a = 1'($urandom);
      tp_b = 8'($urandom);
      tv_b = 1'($urandom);
    end
    check_eq("rst_ready", {31'd0, rdy_a}, 32'd1);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_done", {31'd0, done_a}, 32'd0);
    check_eq("rst_error", {31'd0, err_a}, 32'd0);
    check_eq("rst_set_en", {31'd0, se_a}, 32'd0);
    check_eq("rst_clr_en", {31'd0, ce_a}, 32'd0);
    check_eq("rst_pos_set", {29'd0, ps_a}, 32'd0);
    check_eq("rst_pos_clr", {29'd0, pc_a}, 32'd0);
    tv_a = 1'b0;
    tv_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    preset(1'b0, 8'h00);
    preset(1'b1, 8'h00);

    // Reset during ISSUE drops the enable without a clock edge.
    send(1'b0, 8'h01, acc);
    n = 0;
    while (!se_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_seen", {31'd0, se_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("async_set_en", {31'd0, se_a}, 32'd0);
    check_eq("async_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    preset(1'b0, 8'h00);

    // 2. Two sets: 0x00 -> 0x28.
    e0 = ev_a.size();
    d0 = dn_a.size();
    send(1'b0, 8'h28, acc);
    wait_idle(1'b0);
    check_eq("two_nev", ev_a.size() - e0, 32'd2);
    chk_ev("two_ev0", ev_a[e0], acc + 1, 1'b1, 3'd3, 1'b0, 3'd0);
    chk_ev("two_ev1", ev_a[e0+1], acc + 4, 1'b1, 3'd5, 1'b0, 3'd0);
    check_eq("two_ndone", dn_a.size() - d0, 32'd1);
    check_eq("two_done_cyc", dn_a[d0], acc + 7);
    check_eq("two_state", {24'd0, st_a}, 32'h28);

    // 3. Mixed: 0x28 -> 0x24.
    e0 = ev_a.size();
    d0 = dn_a.size();
    send(1'b0, 8'h24, acc);
    wait_idle(1'b0);
`ifdef CANDLE_SEQ_DUAL_CMD_EN
    check_eq("mix_nev", ev_a.size() - e0, 32'd1);
    chk_ev("mix_ev0", ev_a[e0], acc + 1, 1'b1, 3'd2, 1'b1, 3'd3);
    check_eq("mix_done_cyc", dn_a[d0], acc + 4);
`else
    check_eq("mix_nev", ev_a.size() - e0, 32'd2);
    chk_ev("mix_ev0", ev_a[e0], acc + 1, 1'b1, 3'd2, 1'b0, 3'd0);
    chk_ev("mix_ev1", ev_a[e0+1], acc + 4, 1'b0, 3'd0, 1'b1, 3'd3);
    check_eq("mix_done_cyc", dn_a[d0], acc + 7);
`endif
    check_eq("mix_ndone", dn_a.size() - d0, 32'd1);
    check_eq("mix_state", {24'd0, st_a}, 32'h24);

    // 4. No-op target, then a target_valid while busy.
    e0 = ev_a.size();
    d0 = dn_a.size();
    send(1'b0, 8'h24, acc);
    wait_idle(1'b0);
    check_eq("noop_nev", ev_a.size() - e0, 32'd0);
    check_eq("noop_ndone", dn_a.size() - d0, 32'd1);
    check_eq("noop_done_cyc", dn_a[d0], acc + 1);

    e0 = ev_a.size();
    send(1'b0, 8'h00, acc);
    check_eq("busy_ready", {31'd0, rdy_a}, 32'd0);
    tp_a = 8'hFF;
    tv_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tv_a = 1'b0;
    wait_idle(1'b0);
    check_eq("busy_nev", ev_a.size() - e0, 32'd2);
    chk_ev("busy_ev0", ev_a[e0], acc + 1, 1'b0, 3'd0, 1'b1, 3'd2);
    chk_ev("busy_ev1", ev_a[e0+1], acc + 4, 1'b0, 3'd0, 1'b1, 3'd5);
    check_eq("busy_state", {24'd0, st_a}, 32'h00);

    // 5. Stuck controller on DUT B.
    e0 = ev_b.size();
    d0 = dn_b.size();
    send(1'b1, 8'h40, acc);
    wait_idle(1'b1);
    check_eq("stuck_nev", ev_b.size() - e0, 32'd4);
    for (int k = 0; k < 4; k++)
      chk_ev($sformatf("stuck_ev%0d", k), ev_b[e0+k], acc + 1 + 3 * k, 1'b1, 3'd6, 1'b0, 3'd0);
    check_eq("stuck_error", {31'd0, err_b}, 32'd1);
    check_eq("stuck_ndone", dn_b.size() - d0, 32'd0);
    check_eq("stuck_ready", {31'd0, rdy_b}, 32'd1);
    send(1'b1, 8'h00, acc);
    check_eq("stuck_err_clr", {31'd0, err_b}, 32'd0);
    wait_idle(1'b1);
    check_eq("stuck_err_after", {31'd0, err_b}, 32'd0);

    // 6. Full swap 0x0F -> 0xF0.
    preset(1'b0, 8'h0F);
    e0 = ev_a.size();
    d0 = dn_a.size();
    send(1'b0, 8'hF0, acc);
    wait_idle(1'b0);
`ifdef CANDLE_SEQ_DUAL_CMD_EN
    check_eq("swap_nev", ev_a.size() - e0, 32'd4);
    for (int k = 0; k < 4; k++)
      chk_ev($sformatf("swap_ev%0d", k), ev_a[e0+k], acc + 1 + 3 * k,
             1'b1, 3'(4 + k), 1'b1, 3'(k));
    check_eq("swap_done_cyc", dn_a[d0], acc + 4 * 3 + 1);
`else
    check_eq("swap_nev", ev_a.size() - e0, 32'd8);
    for (int k = 0; k < 4; k++)
      chk_ev($sformatf("swap_set%0d", k), ev_a[e0+k], acc + 1 + 3 * k,
             1'b1, 3'(4 + k), 1'b0, 3'd0);
    for (int k = 0; k < 4; k++)
      chk_ev($sformatf("swap_clr%0d", k), ev_a[e0+4+k], acc + 13 + 3 * k,
             1'b0, 3'd0, 1'b1, 3'(k));
    check_eq("swap_done_cyc", dn_a[d0], acc + 8 * 3 + 1);
`endif
    check_eq("swap_state", {24'd0, st_a}, 32'hF0);
    check_eq("swap_error", {31'd0, err_a}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
